// File: rtl/jesd204_up_tx_ilas_if.sv
// jesd204_up_tx_ilas_if
//
// Register access bus between a microprocessor-side bridge and the ILAS
// configuration block.
//
// Handshake: up_wreq / up_rreq are single-cycle request strobes qualified by
// their address (and write data). The slave answers each request with a
// single-cycle up_wack / up_rack exactly one cycle later. There is no
// back-pressure: a request is always taken in the cycle it is presented.
// up_rdata is valid in the up_rack cycle and holds until the next read.
// Read and write channels are independent and may be active in the same cycle.
//
// Signals:
//   up_wreq  : write request strobe          (master -> slave)
//   up_waddr : 12-bit write word address     (master -> slave)
//   up_wdata : 32-bit write data             (master -> slave)
//   up_wack  : write acknowledge             (slave  -> master)
//   up_rreq  : read request strobe           (master -> slave)
//   up_raddr : 12-bit read word address      (master -> slave)
//   up_rdata : 32-bit registered read data   (slave  -> master)
//   up_rack  : read acknowledge              (slave  -> master)

interface jesd204_up_tx_ilas_if;
    logic        up_wreq;
    logic [11:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [11:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );
endinterface

// File: rtl/jesd204_up_tx_ilas.sv
// jesd204_up_tx_ilas
//
// Register-mapped ILAS configuration for a JESD204 TX link. Holds the
// skip-ILAS / multiframes-per-ILAS settings, a 4 x 32-bit ILAS config memory
// per lane, a saturating counter of writes rejected because the link was
// enabled, and a dirty flag set whenever the ILAS memory is modified.
//
// Ports:
//   up_clk                  : sole clock
//   up_rstn                 : synchronous active-low reset
//   up_bus                  : register read/write bus (slave side)
//   up_cfg_is_writeable     : high while link disabled; gates config writes
//   up_status_ctrl_state    : TX link state, read back at 0x0A0
//   ilas_config_rd          : link layer ILAS word read strobe
//   ilas_config_addr        : ILAS word index 0..3
//   ilas_config_data        : registered ILAS word of every lane (lane i at [32i+31:32i])
//   up_cfg_skip_ilas        : link layer skips ILAS
//   up_cfg_mframes_per_ilas : multiframes per ILAS sequence minus 1
//
// Address map (word addresses):
//   0x090 : bit0 skip_ilas, bits[15:8] mframes_per_ilas
//   0x0A0 : bits[1:0] link state (read-only)
//   0x0A1 : bits[7:0] rejected-write counter (any write clears)
//   0x0A2 : bit0 ilas_dirty (any write clears)
//   0x310 + 8*lane + w : ILAS word w (0..3) of lane

module jesd204_up_tx_ilas #(
    parameter int NUM_LANES       = 1,
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                      up_clk,
    input  logic                      up_rstn,
    jesd204_up_tx_ilas_if.slave       up_bus,
    input  logic                      up_cfg_is_writeable,
    input  logic [1:0]                up_status_ctrl_state,
    input  logic                      ilas_config_rd,
    input  logic [1:0]                ilas_config_addr,
    output logic [32*NUM_LANES-1:0]   ilas_config_data,
    output logic                      up_cfg_skip_ilas,
    output logic [7:0]                up_cfg_mframes_per_ilas
);

    // The ILAS configuration is 16 octets per lane, i.e. 4 core words.
    localparam int ILAS_WORDS = 16 / DATA_PATH_WIDTH;
    localparam int MEM_WORDS  = NUM_LANES * ILAS_WORDS;
    localparam int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [11:0] ADDR_CFG   = 12'h090;
    localparam logic [11:0] ADDR_STATE = 12'h0A0;
    localparam logic [11:0] ADDR_REJ   = 12'h0A1;
    localparam logic [11:0] ADDR_DIRTY = 12'h0A2;
    localparam logic [11:0] ADDR_ILAS  = 12'h310;

    logic [31:0]      mem [MEM_WORDS];
    logic [7:0]       rej_cnt;
    logic             ilas_dirty;

    // Each lane owns an 8-word slot; only the lower 4 words are backed by
    // memory, the upper 4 are holes. Offset bit 2 selects the hole half.
    logic [11:0]      w_off;
    logic [11:0]      r_off;
    logic             w_is_ilas;
    logic             r_is_ilas;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;

    assign w_off     = up_bus.up_waddr - ADDR_ILAS;
    assign r_off     = up_bus.up_raddr - ADDR_ILAS;
    assign w_is_ilas = (up_bus.up_waddr >= ADDR_ILAS) && !w_off[2] &&
                       ({23'd0, w_off[11:3]} < 32'(NUM_LANES));
    assign r_is_ilas = (up_bus.up_raddr >= ADDR_ILAS) && !r_off[2] &&
                       ({23'd0, r_off[11:3]} < 32'(NUM_LANES));
    assign w_idx     = IDX_W'({w_off[11:3], w_off[1:0]});
    assign r_idx     = IDX_W'({r_off[11:3], r_off[1:0]});

    logic wr_cfg;
    logic wr_ilas;
    logic wr_gated;
    logic wr_rej_clr;
    logic wr_dirty_clr;

    assign wr_cfg       = up_bus.up_wreq && (up_bus.up_waddr == ADDR_CFG);
    assign wr_ilas      = up_bus.up_wreq && w_is_ilas;
    assign wr_gated     = wr_cfg || wr_ilas;
    assign wr_rej_clr   = up_bus.up_wreq && (up_bus.up_waddr == ADDR_REJ);
    assign wr_dirty_clr = up_bus.up_wreq && (up_bus.up_waddr == ADDR_DIRTY);

    logic [31:0] rd_val;

    always_comb begin
        rd_val = 32'd0;
        case (up_bus.up_raddr)
            ADDR_CFG:   rd_val = {16'd0, up_cfg_mframes_per_ilas, 7'd0, up_cfg_skip_ilas};
            ADDR_STATE: rd_val = {30'd0, up_status_ctrl_state};
            ADDR_REJ:   rd_val = {24'd0, rej_cnt};
            ADDR_DIRTY: rd_val = {31'd0, ilas_dirty};
            default:    if (r_is_ilas) rd_val = mem[r_idx];
        endcase
    end

    // All reads sample storage before this edge's writes land, so a
    // same-cycle read of a location being written returns the old data.
    always_ff @(posedge up_clk) begin
        if (!up_rstn) begin
            up_bus.up_wack          <= 1'b0;
            up_bus.up_rack          <= 1'b0;
            up_bus.up_rdata         <= 32'd0;
            ilas_config_data        <= '0;
            up_cfg_skip_ilas        <= 1'b0;
            up_cfg_mframes_per_ilas <= 8'd3;
            rej_cnt                 <= 8'd0;
            ilas_dirty              <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            up_bus.up_wack <= up_bus.up_wreq;
            up_bus.up_rack <= up_bus.up_rreq;

            if (up_bus.up_rreq) begin
                up_bus.up_rdata <= rd_val;
            end

            if (ilas_config_rd) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    ilas_config_data[32*i +: 32] <=
                        mem[IDX_W'(i * ILAS_WORDS) + IDX_W'(ilas_config_addr)];
                end
            end

            if (wr_cfg && up_cfg_is_writeable) begin
                up_cfg_skip_ilas        <= up_bus.up_wdata[0];
                up_cfg_mframes_per_ilas <= up_bus.up_wdata[15:8];
            end

            if (wr_ilas && up_cfg_is_writeable) begin
                mem[w_idx] <= up_bus.up_wdata;
            end

            if (wr_rej_clr) begin
                rej_cnt <= 8'd0;
            end else if (wr_gated && !up_cfg_is_writeable && (rej_cnt != 8'hFF)) begin
                rej_cnt <= rej_cnt + 8'd1;
            end

            // Set has priority over clear.
            if (wr_ilas && up_cfg_is_writeable) begin
                ilas_dirty <= 1'b1;
            end else if (wr_dirty_clr) begin
                ilas_dirty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jesd204_up_tx_ilas.sv
// tb_jesd204_up_tx_ilas
//
// Self-checking bench for jesd204_up_tx_ilas with NUM_LANES = 2. A behavioural
// model (per-lane word arrays, plain counters) predicts read data, ILAS
// output data and config outputs; read data goes through an expected queue
// that is popped on each up_rack.

module tb_jesd204_up_tx_ilas;

    localparam int NL = 2;

    // ---------------- clock / reset ----------------
    logic up_clk  = 1'b0;
    logic up_rstn = 1'b0;
    always #5 up_clk = ~up_clk;

    jesd204_up_tx_ilas_if bus ();

    logic              writeable;
    logic [1:0]        ctrl_state;
    logic              cfg_rd;
    logic [1:0]        cfg_addr;
    logic [32*NL-1:0]  cfg_data;
    logic              skip_ilas;
    logic [7:0]        mframes;

    jesd204_up_tx_ilas #(.NUM_LANES(NL), .DATA_PATH_WIDTH(4)) dut (
        .up_clk                  (up_clk),
        .up_rstn                 (up_rstn),
        .up_bus                  (bus.slave),
        .up_cfg_is_writeable     (writeable),
        .up_status_ctrl_state    (ctrl_state),
        .ilas_config_rd          (cfg_rd),
        .ilas_config_addr        (cfg_addr),
        .ilas_config_data        (cfg_data),
        .up_cfg_skip_ilas        (skip_ilas),
        .up_cfg_mframes_per_ilas (mframes)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]      m_mem [NL][4];
    logic             m_skip;
    logic [7:0]       m_mf;
    int               m_rej;
    logic             m_dirty;
    logic [31:0]      exp_q[$];
    logic [31:0]      exp_rdata;
    logic [32*NL-1:0] exp_cfg;

    // Decodes an ILAS memory address into lane / word; returns 0 if unmapped.
    function automatic bit m_ilas_loc(input logic [11:0] a, output int lane, output int w);
        int off;
        lane = 0;
        w    = 0;
        if (int'(a) < 'h310) return 1'b0;
        off  = int'(a) - 'h310;
        lane = off / 8;
        w    = off % 8;
        return (lane < NL) && (w < 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int lane, w;
        if (a == 12'h090) return (32'(m_mf) << 8) | 32'(m_skip);
        if (a == 12'h0A0) return 32'(ctrl_state);
        if (a == 12'h0A1) return 32'(m_rej);
        if (a == 12'h0A2) return 32'(m_dirty);
        if (m_ilas_loc(a, lane, w)) return m_mem[lane][w];
        return 32'd0;
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] d);
        int  lane, w;
        bit  is_ilas;
        is_ilas = m_ilas_loc(a, lane, w);
        if (a == 12'h0A1) begin
            m_rej = 0;
        end else if (a == 12'h0A2) begin
            m_dirty = 1'b0;
        end else if (a == 12'h090 || is_ilas) begin
            if (writeable) begin
                if (is_ilas) begin
                    m_mem[lane][w] = d;
                    m_dirty        = 1'b1;
                end else begin
                    m_skip = d[0];
                    m_mf   = d[15:8];
                end
            end else if (m_rej < 255) begin
                m_rej++;
            end
        end
    endtask

    task automatic m_reset();
        for (int l = 0; l < NL; l++)
            for (int w = 0; w < 4; w++)
                m_mem[l][w] = 32'd0;
        m_skip    = 1'b0;
        m_mf      = 8'd3;
        m_rej     = 0;
        m_dirty   = 1'b0;
        exp_rdata = 32'd0;
        exp_cfg   = '0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // One clock cycle with the given request pattern; inputs change #1 after
    // the edge and outputs are checked #1 after the following edge.
    task automatic step(input bit wreq, input logic [11:0] waddr, input logic [31:0] wdata,
                        input bit rreq, input logic [11:0] raddr,
                        input bit crd, input logic [1:0] caddr);
        bus.up_wreq  = wreq;
        bus.up_waddr = waddr;
        bus.up_wdata = wdata;
        bus.up_rreq  = rreq;
        bus.up_raddr = raddr;
        cfg_rd       = crd;
        cfg_addr     = caddr;
        ctrl_state   = 2'($urandom_range(0, 3));
        if (rreq) exp_q.push_back(m_read(raddr));
        if (crd)
            for (int l = 0; l < NL; l++)
                exp_cfg[32*l +: 32] = m_mem[l][caddr];
        @(posedge up_clk);
        #1;
        check("wack", 64'(bus.up_wack), 64'(wreq));
        check("rack", 64'(bus.up_rack), 64'(rreq));
        if (bus.up_rack && exp_q.size() > 0) exp_rdata = exp_q.pop_front();
        check("rdata", 64'(bus.up_rdata), 64'(exp_rdata));
        check("ilas_data", 64'(cfg_data), 64'(exp_cfg));
        if (wreq) m_write(waddr, wdata);
        check("skip_ilas", 64'(skip_ilas), 64'(m_skip));
        check("mframes", 64'(mframes), 64'(m_mf));
        bus.up_wreq = 1'b0;
        bus.up_rreq = 1'b0;
        cfg_rd      = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 12'h000, 1'b0, 2'd0);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b0, 12'h000, 32'd0, 1'b1, a, 1'b0, 2'd0);
    endtask

    // Read and also compare with a literal from the register map.
    task automatic rd_lit(input string tag, input logic [11:0] a, input logic [31:0] lit);
        rd(a);
        check(tag, 64'(bus.up_rdata), 64'(lit));
    endtask

    // Holds reset for n cycles with optional requests in flight; every
    // output must sit at its reset value throughout.
    task automatic do_reset(input int n, input bit with_req);
        up_rstn      = 1'b0;
        bus.up_wreq  = with_req;
        bus.up_waddr = 12'h310;
        bus.up_wdata = 32'hDEAD_BEEF;
        bus.up_rreq  = with_req;
        bus.up_raddr = 12'h090;
        cfg_rd       = with_req;
        cfg_addr     = 2'd0;
        for (int i = 0; i < n; i++) begin
            @(posedge up_clk);
            #1;
            check("rst_wack", 64'(bus.up_wack), 64'd0);
            check("rst_rack", 64'(bus.up_rack), 64'd0);
            check("rst_rdata", 64'(bus.up_rdata), 64'd0);
            check("rst_ilas", 64'(cfg_data), 64'd0);
            check("rst_skip", 64'(skip_ilas), 64'd0);
            check("rst_mframes", 64'(mframes), 64'd3);
        end
        bus.up_wreq = 1'b0;
        bus.up_rreq = 1'b0;
        cfg_rd      = 1'b0;
        up_rstn     = 1'b1;
        m_reset();
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 11))
            0:       return 12'h090;
            1:       return 12'h0A0;
            2:       return 12'h0A1;
            3:       return 12'h0A2;
            4:       return 12'h010;
            5, 6, 7: return 12'(12'h310 + $urandom_range(0, 'h1F));
            8, 9:    return 12'(12'h310 + $urandom_range(0, 'h0F));
            10:      return 12'(12'h300 + $urandom_range(0, 'h3F));
            default: return 12'($urandom_range(0, 'hFFF));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bus.up_wreq  = 1'b0;
        bus.up_waddr = 12'h000;
        bus.up_wdata = 32'd0;
        bus.up_rreq  = 1'b0;
        bus.up_raddr = 12'h000;
        writeable    = 1'b1;
        ctrl_state   = 2'd0;
        cfg_rd       = 1'b0;
        cfg_addr     = 2'd0;
        m_reset();
        #1;

        // Reset with requests in flight, then read config in the first cycle.
        do_reset(3, 1'b1);
        rd_lit("cfg_after_rst", 12'h090, 32'h0000_0300);

        // ILAS write on lane 1 word 1, dirty flag, link-layer read.
        writeable = 1'b1;
        wr(12'h319, 32'hA5A5_1234);
        rd_lit("dirty_set", 12'h0A2, 32'd1);
        step(1'b0, 12'h000, 32'd0, 1'b0, 12'h000, 1'b1, 2'd1);
        check("ilas_lane1_w1", 64'(cfg_data), {32'hA5A5_1234, 32'd0});
        wr(12'h0A2, 32'd0);
        rd_lit("dirty_clr", 12'h0A2, 32'd0);

        // Rejected writes saturate the counter; writing 0x0A1 clears it.
        writeable = 1'b0;
        for (int i = 0; i < 300; i++) wr(12'h090, 32'($urandom));
        rd_lit("rej_sat", 12'h0A1, 32'd255);
        rd_lit("cfg_unchanged", 12'h090, 32'h0000_0300);
        wr(12'h0A1, 32'd0);
        rd_lit("rej_clr", 12'h0A1, 32'd0);

        // Read-during-write returns the old value on both read ports.
        writeable = 1'b1;
        step(1'b1, 12'h310, 32'h11, 1'b1, 12'h310, 1'b1, 2'd0);
        check("rdw_reg_old", 64'(bus.up_rdata), 64'd0);
        check("rdw_ilas_old", 64'(cfg_data[31:0]), 64'd0);
        step(1'b0, 12'h000, 32'd0, 1'b1, 12'h310, 1'b1, 2'd0);
        check("rdw_reg_new", 64'(bus.up_rdata), 64'h11);
        check("rdw_ilas_new", 64'(cfg_data[31:0]), 64'h11);

        // Holes, lanes beyond NUM_LANES and read-only registers.
        writeable = 1'b0;
        wr(12'h314, 32'hFFFF_FFFF);
        wr(12'h320, 32'hFFFF_FFFF);
        wr(12'h0A0, 32'hFFFF_FFFF);
        wr(12'h010, 32'hFFFF_FFFF);
        rd_lit("hole_314", 12'h314, 32'd0);
        rd_lit("lane2_320", 12'h320, 32'd0);
        rd_lit("rej_unmapped", 12'h0A1, 32'd0);
        writeable = 1'b1;
        wr(12'h314, 32'hFFFF_FFFF);
        rd_lit("hole_314_w", 12'h314, 32'd0);
        rd_lit("alias_310", 12'h310, 32'h11);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) writeable = ~writeable;
            step(1'($urandom_range(0, 1)), pick_addr(), 32'($urandom),
                 1'($urandom_range(0, 1)), pick_addr(),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Reset in the cycle after a write: no ack, memory cleared.
        writeable = 1'b1;
        wr(12'h311, 32'hCAFE_F00D);
        do_reset(1, 1'b0);
        for (int l = 0; l < NL; l++)
            for (int w = 0; w < 4; w++)
                rd_lit("mem_cleared", 12'(12'h310 + 8 * l + w), 32'd0);
        for (int w = 0; w < 4; w++)
            step(1'b0, 12'h000, 32'd0, 1'b0, 12'h000, 1'b1, 2'(w));
        rd_lit("cfg_after_rst2", 12'h090, 32'h0000_0300);
        rd_lit("rej_after_rst", 12'h0A1, 32'd0);
        rd_lit("dirty_after_rst", 12'h0A2, 32'd0);

        step(1'b0, 12'h000, 32'd0, 1'b0, 12'h000, 1'b0, 2'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
